// File: rtl/fu_share_sched_pkg.sv
// Shared encodings and arithmetic kernels for the shared functional-unit scheduler.
package fu_share_sched_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_MUL = 1'b1;

    // Multiplier products are scaled back into range by this arithmetic shift.
    localparam int SHIFT_WIDTH = 8;

    typedef enum logic [1:0] {
        MODE_ADD0 = 2'd0,  // upper 24 bits summed, low 8 bits zero
        MODE_ADD2 = 2'd1,  // upper 28 bits summed, low 4 bits zero
        MODE_ADD1 = 2'd2,  // upper 24 bits summed, low 8 bits OR-approximated
        MODE_ADD3 = 2'd3   // exact
    } add_mode_e;

    typedef struct packed {
        logic        op;
        logic [1:0]  mode;
        logic [31:0] a;
        logic [31:0] b;
    } op_t;

    function automatic logic is_exact(input logic op, input logic [1:0] mode);
        return (op == OP_MUL) ? mode[0] : (mode == MODE_ADD3);
    endfunction

    function automatic logic [31:0] add_0(input logic [31:0] a, input logic [31:0] b);
        return ((a >> 8) + (b >> 8)) << 8;
    endfunction

    function automatic logic [31:0] add_2(input logic [31:0] a, input logic [31:0] b);
        return ((a >> 4) + (b >> 4)) << 4;
    endfunction

    // Lower-part-OR adder: no carry out of the low byte.
    function automatic logic [31:0] add_1(input logic [31:0] a, input logic [31:0] b);
        return (((a >> 8) + (b >> 8)) << 8) | ((a | b) & 32'h0000_00ff);
    endfunction

    function automatic logic [31:0] add_3(input logic [31:0] a, input logic [31:0] b);
        return a + b;
    endfunction

    function automatic logic [31:0] mul_scale(input logic [31:0] p);
        logic signed [31:0] ps;
        ps = p;
        return ps >>> SHIFT_WIDTH;
    endfunction

    // Approximate multiplier: low nibble of each operand dropped; zero operand forces zero.
    function automatic logic [31:0] mul_0(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] p;
        if ((a == '0) || (b == '0)) p = '0;
        else                        p = (a & ~32'hf) * (b & ~32'hf);
        return mul_scale(p);
    endfunction

    function automatic logic [31:0] mul_1(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] p;
        p = a * b;
        return mul_scale(p);
    endfunction

    // Result mux over all units; bit 1 of the mode is ignored for multiplies.
    function automatic logic [31:0] fu_compute(input op_t o);
        logic [31:0] r;
        r = '0;
        if (o.op == OP_MUL) begin
            r = o.mode[0] ? mul_1(o.a, o.b) : mul_0(o.a, o.b);
        end else begin
            case (add_mode_e'(o.mode))
                MODE_ADD0: r = add_0(o.a, o.b);
                MODE_ADD2: r = add_2(o.a, o.b);
                MODE_ADD1: r = add_1(o.a, o.b);
                default:   r = add_3(o.a, o.b);
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/fu_share_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr, wrapping.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    // Scan NREQ positions starting at the pointer and take the first active one.
    always_comb begin
        int c;
        // NOTE: every output gets a default before the loop so no path leaves a latch.
        gnt = '0;
        idx = '0;
        any = 1'b0;
        c   = 0;
        for (int k = 0; k < NREQ; k++) begin
            c = (int'(ptr) + k) % NREQ;
            if (!any && req[c]) begin
                any    = 1'b1;
                gnt[c] = 1'b1;
                idx    = IDW'(c);
            end
        end
    end

endmodule

// File: rtl/fu_share_sched.sv
// One shared arithmetic slot: round-robin issue, fixed-latency pipeline, usage counters.
module fu_share_sched
    import fu_share_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int LAT  = 2,
    parameter int CNTW = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ-1:0]    req_op,
    input  logic [2*NREQ-1:0]  req_mode,
    input  logic [32*NREQ-1:0] req_a,
    input  logic [32*NREQ-1:0] req_b,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [IDW-1:0]     rsp_id,
    output logic [31:0]        rsp_data,
    output logic [CNTW-1:0]    cnt_approx,
    output logic [CNTW-1:0]    cnt_exact
);

    logic              adv, accept, gnt_any;
    logic [NREQ-1:0]   gnt;
    logic [IDW-1:0]    gnt_idx;
    logic [IDW-1:0]    ptr_q, ptr_d;
    logic              s1_vld_q, s1_vld_d;
    logic [IDW-1:0]    s1_id_q, s1_id_d;
    op_t               s1_op_q, s1_op_d;
    logic [31:0]       s1_res;
    logic [CNTW-1:0]   cnt_approx_q, cnt_approx_d, cnt_exact_q, cnt_exact_d;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (gnt),
        .idx (gnt_idx),
        .any (gnt_any)
    );

    // The whole pipeline moves as one unit whenever the output slot can drain.
    assign adv       = !rsp_valid || rsp_ready;
    assign req_ready = (rst_n && adv) ? gnt : '0;
    assign accept    = rst_n && adv && gnt_any;
    assign s1_res    = fu_compute(s1_op_q);

    assign cnt_approx = cnt_approx_q;
    assign cnt_exact  = cnt_exact_q;

    // Next state for the pointer, stage 1 and the saturating issue counters.
    always_comb begin
        ptr_d        = ptr_q;
        s1_vld_d     = s1_vld_q;
        s1_id_d      = s1_id_q;
        s1_op_d      = s1_op_q;
        cnt_approx_d = cnt_approx_q;
        cnt_exact_d  = cnt_exact_q;
        if (adv) begin
            s1_vld_d = accept;
        end
        if (accept) begin
            s1_id_d      = gnt_idx;
            s1_op_d.op   = req_op[gnt_idx];
            s1_op_d.mode = req_mode[gnt_idx*2 +: 2];
            s1_op_d.a    = req_a[gnt_idx*32 +: 32];
            s1_op_d.b    = req_b[gnt_idx*32 +: 32];
            ptr_d        = IDW'((int'(gnt_idx) + 1) % NREQ);
            if (is_exact(s1_op_d.op, s1_op_d.mode)) begin
                if (cnt_exact_q != '1) cnt_exact_d = cnt_exact_q + 1'b1;
            end else begin
                if (cnt_approx_q != '1) cnt_approx_d = cnt_approx_q + 1'b1;
            end
        end
    end

    // Register pointer, stage 1 and counters; synchronous reset clears them all.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with <= so every flop samples pre-edge values.
        if (!rst_n) begin
            ptr_q        <= '0;
            s1_vld_q     <= 1'b0;
            s1_id_q      <= '0;
            s1_op_q      <= '0;
            cnt_approx_q <= '0;
            cnt_exact_q  <= '0;
        end else begin
            ptr_q        <= ptr_d;
            s1_vld_q     <= s1_vld_d;
            s1_id_q      <= s1_id_d;
            s1_op_q      <= s1_op_d;
            cnt_approx_q <= cnt_approx_d;
            cnt_exact_q  <= cnt_exact_d;
        end
    end

    if (LAT == 1) begin : g_lat1
        assign rsp_valid = s1_vld_q;
        assign rsp_id    = s1_id_q;
        assign rsp_data  = s1_res;
    end else begin : g_pipe
        logic [LAT-2:0] vld_q, vld_d;
        logic [IDW-1:0] id_q  [LAT-1];
        logic [IDW-1:0] id_d  [LAT-1];
        logic [31:0]    dat_q [LAT-1];
        logic [31:0]    dat_d [LAT-1];

        // Shift the computed result down the delay line when the pipeline advances.
        always_comb begin
            vld_d = vld_q;
            id_d  = id_q;
            dat_d = dat_q;
            if (adv) begin
                vld_d[0] = s1_vld_q;
                id_d[0]  = s1_id_q;
                dat_d[0] = s1_res;
                for (int i = 1; i < LAT - 1; i++) begin
                    vld_d[i] = vld_q[i-1];
                    id_d[i]  = id_q[i-1];
                    dat_d[i] = dat_q[i-1];
                end
            end
        end

        // Result stages; payload is cleared too so rsp_id/rsp_data read zero after reset.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                vld_q <= '0;
                // NOTE: the payload arrays are reset on purpose, because the outputs must be 0.
                for (int i = 0; i < LAT - 1; i++) begin
                    id_q[i]  <= '0;
                    dat_q[i] <= '0;
                end
            end else begin
                vld_q <= vld_d;
                id_q  <= id_d;
                dat_q <= dat_d;
            end
        end

        assign rsp_valid = vld_q[LAT-2];
        assign rsp_id    = id_q[LAT-2];
        assign rsp_data  = dat_q[LAT-2];
    end

endmodule

// File: tb/tb_fu_share_sched.sv
// Scoreboard bench for fu_share_sched: directed scenarios plus a random stream.
module tb_fu_share_sched;

    localparam int NREQ  = 4;
    localparam int IDW   = 2;
    localparam int LAT   = 2;
    localparam int CNTW  = 5;
    localparam int CMAX  = (1 << CNTW) - 1;
    localparam int SHIFT = fu_share_sched_pkg::SHIFT_WIDTH;

    logic               clk;
    logic               rst_n;
    logic [NREQ-1:0]    req_valid, req_ready, req_op;
    logic [2*NREQ-1:0]  req_mode;
    logic [32*NREQ-1:0] req_a, req_b;
    logic               rsp_valid, rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [31:0]        rsp_data;
    logic [CNTW-1:0]    cnt_approx, cnt_exact;

    fu_share_sched #(.NREQ(NREQ), .IDW(IDW), .LAT(LAT), .CNTW(CNTW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_mode   (req_mode),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .cnt_approx (cnt_approx),
        .cnt_exact  (cnt_exact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Requester-side stimulus state.
    logic        pend_v    [NREQ];
    logic        pend_op   [NREQ];
    logic [1:0]  pend_mode [NREQ];
    logic [31:0] pend_a    [NREQ];
    logic [31:0] pend_b    [NREQ];

    always_comb begin
        req_valid = '0;
        req_op    = '0;
        req_mode  = '0;
        req_a     = '0;
        req_b     = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]        = pend_v[i];
            req_op[i]           = pend_op[i];
            req_mode[2*i +: 2]  = pend_mode[i];
            req_a[32*i +: 32]   = pend_a[i];
            req_b[32*i +: 32]   = pend_b[i];
        end
    end

    typedef struct {
        int          id;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   grant_log[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic, written from the unit descriptions.
    function automatic logic [31:0] ref_result(input logic op, input logic [1:0] mode,
                                               input logic [31:0] a, input logic [31:0] b);
        logic [31:0]        p;
        logic signed [31:0] ps;
        logic [23:0]        hi8;
        logic [27:0]        hi4;
        hi8 = a[31:8] + b[31:8];
        hi4 = a[31:4] + b[31:4];
        if (op) begin
            if (mode[0])                 p = a * b;
            else if (a == 0 || b == 0)   p = 32'd0;
            else                         p = {a[31:4], 4'h0} * {b[31:4], 4'h0};
            ps = p;
            return ps >>> SHIFT;
        end
        case (mode)
            2'd0:    return {hi8, 8'h00};
            2'd1:    return {hi4, 4'h0};
            2'd2:    return {hi8, a[7:0] | b[7:0]};
            default: return a + b;
        endcase
    endfunction

    // Reference model: RR pointer, a delay line of occupancy bits, counters.
    int             ptr_m  = 0;
    logic [LAT-1:0] v_m    = '0;
    int             cap_m  = 0;
    int             cex_m  = 0;
    int             acc_idx = -1;

    always @(negedge clk) begin : model_p
        int             g;
        int             c;
        logic           adv_m;
        logic [NREQ-1:0] exp_rdy;
        g = -1;
        for (int k = 0; k < NREQ; k++) begin
            c = (ptr_m + k) % NREQ;
            if (g < 0 && pend_v[c]) g = c;
        end
        adv_m   = !v_m[LAT-1] || rsp_ready;
        exp_rdy = '0;
        if (rst_n && adv_m && g >= 0) exp_rdy[g] = 1'b1;
        check("req_ready", req_ready, exp_rdy);
        check("rsp_valid", rsp_valid, v_m[LAT-1]);
        check("cnt_approx", cnt_approx, cap_m);
        check("cnt_exact", cnt_exact, cex_m);
        acc_idx = (exp_rdy != '0) ? g : -1;
        if (!rst_n) begin
            v_m   = '0;
            ptr_m = 0;
            cap_m = 0;
            cex_m = 0;
            sb.delete();
        end else if (adv_m) begin
            v_m = (v_m << 1) | LAT'(acc_idx >= 0);
            if (acc_idx >= 0) begin
                sb.push_back('{g, ref_result(pend_op[g], pend_mode[g], pend_a[g], pend_b[g])});
                ptr_m = (g + 1) % NREQ;
                if (pend_op[g] ? pend_mode[g][0] : (pend_mode[g] == 2'd3)) begin
                    if (cex_m < CMAX) cex_m++;
                end else begin
                    if (cap_m < CMAX) cap_m++;
                end
            end
        end
    end

    // Monitor: every presented result must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rsp_unexpected: got id %0d data 0x%0h with nothing outstanding", rsp_id, rsp_data);
            end else begin
                check("rsp_id", rsp_id, sb[0].id);
                check("rsp_data", rsp_data, sb[0].data);
                if (rsp_ready) void'(sb.pop_front());
            end
        end
    end

    int refill   = 0;   // 0: drop on accept, 1: always replace, 2: random traffic
    int last_acc = -1;

    task automatic new_op(input int i);
        int s;
        pend_v[i]    = 1'b1;
        pend_op[i]   = 1'($urandom_range(0, 1));
        pend_mode[i] = 2'($urandom_range(0, 3));
        s = $urandom_range(0, 3);
        pend_a[i] = (s == 0) ? 32'd0 : (s == 1) ? 32'($urandom_range(0, 255)) : $urandom;
        s = $urandom_range(0, 3);
        pend_b[i] = (s == 0) ? 32'd0 : (s == 1) ? 32'($urandom_range(0, 4095)) : $urandom;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        last_acc = acc_idx;
        if (acc_idx >= 0) begin
            grant_log.push_back(acc_idx);
            if (refill == 1) new_op(acc_idx);
            else             pend_v[acc_idx] = 1'b0;
        end
        if (refill == 2) begin
            for (int i = 0; i < NREQ; i++)
                if (!pend_v[i] && $urandom_range(0, 2) == 0) new_op(i);
        end
    endtask

    task automatic set_op(input int i, input logic op, input logic [1:0] mode,
                          input logic [31:0] a, input logic [31:0] b);
        pend_v[i]    = 1'b1;
        pend_op[i]   = op;
        pend_mode[i] = mode;
        pend_a[i]    = a;
        pend_b[i]    = b;
    endtask

    task automatic run_one(input string name, input int id, input logic op, input logic [1:0] mode,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        int n;
        logic ok;
        set_op(id, op, mode, a, b);
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            tick();
            if (last_acc == id) ok = 1'b1;
        end
        check({name, "_accepted"}, ok, 1'b1);
        if (!ok) return;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 10);
        check({name, "_latency"}, n, LAT);
        check({name, "_id"}, rsp_id, id);
        check({name, "_data"}, rsp_data, exp);
    endtask

    task automatic drain();
        int k;
        logic busy;
        refill    = 0;
        rsp_ready = 1'b1;
        k = 0;
        do begin
            busy = sb.size() > 0;
            for (int i = 0; i < NREQ; i++) busy = busy | pend_v[i];
            if (busy) tick();
            k++;
        end while (busy && k < 100);
        check("drain_complete", busy, 1'b0);
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        repeat (cycles) tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) new_op(i);

        // 1: reset with every requester asking.
        tick();
        tick();
        @(negedge clk);
        check("rst_req_ready", req_ready, '0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_id", rsp_id, '0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_cnt_approx", cnt_approx, '0);
        check("rst_cnt_exact", cnt_exact, '0);
        tick();
        for (int i = 0; i < NREQ; i++) pend_v[i] = 1'b0;
        rst_n = 1'b1;

        // 2: exact and truncated add.
        run_one("add_exact", 0, 1'b0, 2'd3, 32'h105, 32'hff, 32'h204);
        run_one("add_mode0", 0, 1'b0, 2'd0, 32'h105, 32'hff, 32'h100);
        check("t2_cnt_exact", cnt_exact, 5'd1);
        check("t2_cnt_approx", cnt_approx, 5'd1);

        // 3: multiplies.
        run_one("mul_exact", 0, 1'b1, 2'd1, 32'h100, 32'h200, 32'h200);
        run_one("mul_zero", 0, 1'b1, 2'd0, 32'h100, 32'h0, 32'h0);
        run_one("mul_mode3", 2, 1'b1, 2'd3, 32'h7, 32'h9, 32'h0);

        // 4: RR fairness from a fresh pointer.
        do_reset(1);
        for (int i = 0; i < NREQ; i++) new_op(i);
        refill = 1;
        grant_log.delete();
        repeat (8) tick();
        refill = 0;
        for (int i = 0; i < NREQ; i++) pend_v[i] = 1'b0;
        check("rr_count", grant_log.size(), 8);
        for (int i = 0; i < 8 && i < grant_log.size(); i++)
            check($sformatf("rr_grant%0d", i), grant_log[i], i % NREQ);
        drain();

        // 5: backpressure mid-stream.
        for (int i = 0; i < NREQ; i++) new_op(i);
        refill = 1;
        repeat (4) tick();
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_req_ready", req_ready, '0);
            check("bp_rsp_valid", rsp_valid, 1'b1);
            if (sb.size() > 0) check("bp_rsp_hold", rsp_data, sb[0].data);
            tick();
        end
        rsp_ready = 1'b1;
        drain();

        // 6: reset with two ops in flight, then pointer restart.
        rsp_ready = 1'b0;
        new_op(0);
        new_op(1);
        tick();
        tick();
        do_reset(1);
        rsp_ready = 1'b1;
        for (int i = 0; i < LAT + 2; i++) begin
            @(negedge clk);
            check("rst_flight_rsp_valid", rsp_valid, 1'b0);
            tick();
        end
        for (int i = 0; i < NREQ; i++) new_op(i);
        for (int i = 1; i < NREQ; i++) pend_v[i] = 1'b0;
        new_op(2);
        new_op(3);
        tick();
        check("ptr_restart", last_acc, 0);
        drain();

        // Random traffic long enough to saturate both counters.
        refill = 2;
        repeat (1500) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();
        @(negedge clk);
        check("sat_cnt_approx", cnt_approx, CMAX);
        check("sat_cnt_exact", cnt_exact, CMAX);
        check("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
